// File: rtl/button_frame_sync.sv
// button_frame_sync: debounce three raw buttons and latch them once per video frame
module button_frame_sync #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int FRAME_COUNT_WIDTH = 8
) (
   input  logic                         CLK,
   input  logic                         RESET,
   input  logic                         VSYNC_START,
   input  logic                         BTN_LEFT_RAW,
   input  logic                         BTN_RIGHT_RAW,
   input  logic                         BTN_RELEASE_RAW,
   output logic                         START_UPDATE,
   output logic                         BTN_LEFT,
   output logic                         BTN_RIGHT,
   output logic                         BTN_RELEASE,
   output logic [FRAME_COUNT_WIDTH-1:0] FRAME_COUNT
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
   logic [2:0] sync1_q, sync1_d, sync2_q, sync2_d, deb_q, deb_d;
   logic [2:0][CW-1:0] cnt_q, cnt_d;
   logic pending_q, pending_d, vs_prev_q, vs_prev_d, start_q, start_d;
   logic left_q, left_d, right_q, right_d, release_q, release_d;
   logic [FRAME_COUNT_WIDTH-1:0] fc_q, fc_d;
   logic rel_edge, frame_ev;
   // synchronize, debounce, detect frame events and compute next frame-stable outputs
   always_comb begin
      sync1_d = {BTN_RELEASE_RAW, BTN_RIGHT_RAW, BTN_LEFT_RAW};
      sync2_d = sync1_q;
      for (int i = 0; i < 3; i++) begin
         deb_d[i] = (sync2_q[i] != deb_q[i] && cnt_q[i] == CMAX) ? sync2_q[i] : deb_q[i];
         cnt_d[i] = (sync2_q[i] != deb_q[i] && cnt_q[i] != CMAX) ? cnt_q[i] + 1'b1 : '0;
      end
      rel_edge = deb_d[2] & ~deb_q[2];
      frame_ev = VSYNC_START & ~vs_prev_q;
      vs_prev_d = VSYNC_START;
      start_d = frame_ev;
      left_d = frame_ev ? deb_q[0] : left_q;
      right_d = frame_ev ? deb_q[1] : right_q;
      release_d = frame_ev ? (pending_q | rel_edge) : release_q;
      pending_d = frame_ev ? 1'b0 : (pending_q | rel_edge);
      fc_d = frame_ev ? fc_q + 1'b1 : fc_q;
   end
   // state registers, reset overrides every event
   always_ff @(posedge CLK) begin
      if (RESET) begin
         sync1_q <= '0;
         sync2_q <= '0;
         deb_q <= '0;
         cnt_q <= '0;
         pending_q <= 1'b0;
         vs_prev_q <= 1'b0;
         start_q <= 1'b0;
         left_q <= 1'b0;
         right_q <= 1'b0;
         release_q <= 1'b0;
         fc_q <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         deb_q <= deb_d;
         cnt_q <= cnt_d;
         pending_q <= pending_d;
         vs_prev_q <= vs_prev_d;
         start_q <= start_d;
         left_q <= left_d;
         right_q <= right_d;
         release_q <= release_d;
         fc_q <= fc_d;
      end
   end
   assign START_UPDATE = start_q;
   assign BTN_LEFT = left_q;
   assign BTN_RIGHT = right_q;
   assign BTN_RELEASE = release_q;
   assign FRAME_COUNT = fc_q;
endmodule

// File: tb/tb_button_frame_sync.sv
// tb_button_frame_sync: scoreboard bench with a window-based debounce reference model
module tb_button_frame_sync;
   localparam int N = 4;
   localparam int W = 3;
   typedef struct packed {
      logic l;
      logic r;
      logic rel;
      logic [W-1:0] fc;
   } exp_t;
   logic clk = 0, rst = 1, vs = 0, bl = 0, br = 0, brel = 0;
   logic start_update, btn_left, btn_right, btn_release;
   logic [W-1:0] frame_count;
   int checks = 0, errors = 0;
   exp_t sbq[$];
   bit raw_h[3][$];
   bit win[3][$];
   bit md[3];
   bit m_pend, m_vprev;
   exp_t m_out;
   always #5 clk = ~clk;
   button_frame_sync #(.DEBOUNCE_CYCLES(N), .FRAME_COUNT_WIDTH(W)) dut (
      .CLK(clk), .RESET(rst), .VSYNC_START(vs),
      .BTN_LEFT_RAW(bl), .BTN_RIGHT_RAW(br), .BTN_RELEASE_RAW(brel),
      .START_UPDATE(start_update), .BTN_LEFT(btn_left), .BTN_RIGHT(btn_right),
      .BTN_RELEASE(btn_release), .FRAME_COUNT(frame_count)
   );
   task automatic model_reset();
      for (int b = 0; b < 3; b++) begin
         raw_h[b] = {};
         win[b] = {};
         repeat (2) raw_h[b].push_back(1'b0);
         repeat (N) win[b].push_back(1'b0);
         md[b] = 1'b0;
      end
      m_pend = 1'b0;
      m_vprev = 1'b0;
      m_out = '0;
   endtask
   initial model_reset();
   // reference: a button level is accepted once the last N synchronized samples all disagree with it
   always @(posedge clk) begin
      bit raw[3];
      bit old_d[3];
      bit s, flip, rel_edge, ev;
      raw = '{bl, br, brel};
      if (rst) model_reset();
      else begin
         for (int b = 0; b < 3; b++) begin
            old_d[b] = md[b];
            s = raw_h[b].pop_front();
            raw_h[b].push_back(raw[b]);
            void'(win[b].pop_front());
            win[b].push_back(s);
            flip = 1'b1;
            foreach (win[b][j]) if (win[b][j] == md[b]) flip = 1'b0;
            if (flip) md[b] = !md[b];
         end
         rel_edge = md[2] && !old_d[2];
         ev = vs && !m_vprev;
         m_vprev = vs;
         if (ev) begin
            m_out.l = old_d[0];
            m_out.r = old_d[1];
            m_out.rel = m_pend || rel_edge;
            m_out.fc = m_out.fc + 1'b1;
            m_pend = 1'b0;
            sbq.push_back(m_out);
         end else m_pend = m_pend || rel_edge;
      end
   end
   task automatic cmp(string n, exp_t a, exp_t e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s got l=%b r=%b rel=%b fc=%0d want l=%b r=%b rel=%b fc=%0d",
                  n, a.l, a.r, a.rel, a.fc, e.l, e.r, e.rel, e.fc);
      end
   endtask
   // monitor: pop on every START_UPDATE, otherwise outputs must hold the model's frame values
   always @(negedge clk) begin
      exp_t a;
      a = {btn_left, btn_right, btn_release, frame_count};
      if (start_update === 1'b1) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_start got start=1 want start=0");
         end else cmp("frame", a, sbq.pop_front());
      end else begin
         if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL missing_start got start=%b want start=1", start_update);
            void'(sbq.pop_front());
         end
         cmp("hold", a, m_out);
      end
   end
   task automatic tick(int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic frame(int len);
      vs = 1;
      tick(len);
      vs = 0;
      tick(3);
   endtask
   initial begin
      tick(3);
      rst = 0;
      tick(1);
      bl = 1;
      tick(10);
      frame(1);
      tick(5);
      br = 1; tick(2); br = 0; tick(2); br = 1; tick(2); br = 0; tick(2); br = 1;
      tick(10);
      frame(1);
      brel = 1;
      tick(8);
      brel = 0;
      tick(3);
      frame(1);
      tick(10);
      frame(1);
      brel = 1;
      tick(5);
      vs = 1;
      tick(2);
      vs = 0;
      brel = 0;
      tick(10);
      frame(1);
      frame(5);
      repeat (9) frame(1);
      bl = 0;
      brel = 1;
      tick(7);
      brel = 0;
      tick(2);
      rst = 1;
      tick(1);
      rst = 0;
      tick(2);
      frame(1);
      bl = 1;
      br = 1;
      tick(10);
      frame(1);
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 9) == 0) bl = ~bl;
         if ($urandom_range(0, 9) == 0) br = ~br;
         if ($urandom_range(0, 7) == 0) brel = ~brel;
         vs = ($urandom_range(0, 19) == 0) || (vs && $urandom_range(0, 2) != 0);
         rst = ($urandom_range(0, 499) == 0);
         tick(1);
      end
      rst = 0;
      vs = 0;
      tick(3);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/button_frame_sync.md
# button_frame_sync

Input conditioning and frame-pacing stage that sits directly upstream of the game logic. It synchronizes and debounces the three raw board buttons. Once per video frame, on the vertical-sync start pulse from the VGA timing generator, it latches them into frame-stable levels and issues the one-cycle `START_UPDATE` that releases the game logic's 12-step frame. It also maintains a free-running frame counter for seeding the initial ball velocity.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 250000: consecutive cycles a synchronized level must differ from the debounced state before it is accepted (5 ms at 50 MHz). Legal range is 2 to 2^20.
- `FRAME_COUNT_WIDTH`, default 8: width of `FRAME_COUNT`.

Ports (clock and reset first):
- `CLK` input 1: system clock; one clock domain only.
- `RESET` input 1: synchronous, active-high reset.
- `VSYNC_START` input 1: from the VGA timing generator; high for one or more cycles at start of vertical blank.
- `BTN_LEFT_RAW` input 1: raw active-high button, asynchronous.
- `BTN_RIGHT_RAW` input 1: raw active-high button, asynchronous.
- `BTN_RELEASE_RAW` input 1: raw active-high button, asynchronous.
- `START_UPDATE` output 1: one-cycle pulse per frame, to the game logic.
- `BTN_LEFT` output 1: debounced left level, frozen for the frame.
- `BTN_RIGHT` output 1: debounced right level, frozen for the frame.
- `BTN_RELEASE` output 1: high for a whole frame if a release press occurred during the previous frame.
- `FRAME_COUNT` output `FRAME_COUNT_WIDTH`: number of frame updates issued, mod 2^width.

## Operation
- **Synchronizer:** two flip-flop stages per raw input. The second stage is the synchronized level `s`.
- **Debouncer:** one per button. Each keeps a stable level `d` and a counter `c` of width ceil(log2(DEBOUNCE_CYCLES)).
  - If `s == d`: `c <= 0`.
  - Else if `c == DEBOUNCE_CYCLES-1`: `d <= s` and `c <= 0`.
  - Else: `c <= c+1`.
  - Any bounce back to `d` restarts the count.
- **Release edge:** `rel_edge` is the cycle in which the release debouncer's `d` goes 0->1. It sets the `pending` flag.
- **Frame event:** the rising edge of `VSYNC_START`, registered-previous-value compare. A level held high produces exactly one event.
- **On a frame event:**
  - `BTN_LEFT <= d_left` and `BTN_RIGHT <= d_right`.
  - `BTN_RELEASE <= pending | rel_edge`, then `pending <= 0`.
  - `FRAME_COUNT <= FRAME_COUNT+1`, wrapping to 0 at max.
  - `START_UPDATE <= 1`.
- **All other cycles:** `START_UPDATE <= 0`. The other outputs hold their values. `pending <= pending | rel_edge`.
- **Simultaneous events:**
  - `rel_edge` in the same cycle as a frame event is reported in that frame, and `pending` ends at 0.
  - Left and right both high are passed through unchanged; the game logic cancels them.
- **Reset:** all outputs 0 and all internal state 0 (sync stages, `d`, `c`, `pending`, previous `VSYNC_START`).
  - `VSYNC_START` high in the first cycle after reset counts as a rising edge.
  - Reset mid-debounce discards the partial count.
  - Reset takes priority over every event in the same cycle.

## Timing
- **Raw to sync:** a raw change present before edge k appears on `s` after edge k+1.
- **Sync to debounced:** `d` changes at the `DEBOUNCE_CYCLES`-th consecutive edge at which `s != d`. With `DEBOUNCE_CYCLES`=4, a clean raw step before edge k flips `d` after edge k+5.
- **Frame-event latency:** if `VSYNC_START` rises before edge f, then after edge f `START_UPDATE`=1 and the new `BTN_*` and `FRAME_COUNT` values are visible in that same cycle. `START_UPDATE` returns to 0 after edge f+1.
- **Output stability:** `BTN_*` outputs are constant between frame events, so the game logic sees identical inputs in all 12 timesteps.
- **No backpressure:** the game logic is idle waiting for `START_UPDATE` well before the next vsync; its frame costs about 48 cycles.

## Test plan
Run all scenarios with `DEBOUNCE_CYCLES`=4 and `FRAME_COUNT_WIDTH`=3.
1. **Clean press:** `BTN_LEFT_RAW` 0->1 before edge 10, held; `VSYNC_START` pulses before edge 20 -> `d_left`=1 after edge 15; `BTN_LEFT`=1 and `START_UPDATE`=1 only in the cycle after edge 20.
2. **Bounce:** raw toggles 1,0,1,0 every 2 cycles, then held 1 -> `d` never changes during the toggling; `d` goes to 1 exactly 4 edges after `s` settles high.
3. **Release latching:** a release press is debounced between frames; raw is released before the frame event -> `BTN_RELEASE`=1 for the whole next frame, then 0 on the following frame event. A release edge in the same cycle as a frame event -> `BTN_RELEASE`=1 in that frame, and 0 in the next.
4. **Vsync held 5 cycles, frame counter wrap:** `VSYNC_START` held high for 5 cycles -> exactly one `START_UPDATE` pulse. Nine frame events -> `FRAME_COUNT` sequence 1..7,0,1.
5. **Reset mid-operation:** `RESET` asserted during a debounce count and with `pending`=1 -> all outputs 0 next cycle. After deassertion, the next frame event gives `BTN_RELEASE`=0.
6. **Both directions:** left and right both held -> `BTN_LEFT`=`BTN_RIGHT`=1 in the same frame.
